// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage, the muldiv unit and the register file write port.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;

    // Issue side: drives the request, observes status and the write-back.
    modport master (
        output start, funct3, rs1_val, rs2_val, rd_in,
        input  busy, done, we, rd, wdata
    );

    // Execution unit side.
    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_in,
        output busy, done, we, rd, wdata
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: fixed 33-edge latency, one-cycle register file write.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam int unsigned PW    = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        dest_q, dest_d;
    // hi/lo: product high/low halves for multiply; remainder/quotient for divide.
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    // Magnitude added (multiply) or subtracted (divide) each iteration.
    logic [XLEN-1:0]   opnd_q, opnd_d;
    // Negate the selected result at completion.
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic              a_signed_c, b_signed_c;
    logic              a_neg_c, b_neg_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c;
    logic [XLEN:0]     mul_sum_c;
    logic [XLEN:0]     div_shift_c;
    logic [XLEN:0]     div_diff_c;
    logic              div_ge_c;
    logic [PW-1:0]     prod_c;
    logic [XLEN-1:0]   div_raw_c;
    logic [XLEN-1:0]   result_c;

    // Operand signedness and magnitudes of the incoming request.
    always_comb begin
        a_signed_c = 1'b0;
        b_signed_c = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_c = 1'b1;
                b_signed_c = 1'b1;
            end
            3'b010: begin
                a_signed_c = 1'b1;
                b_signed_c = 1'b0;
            end
            default: begin
                a_signed_c = 1'b0;
                b_signed_c = 1'b0;
            end
        endcase
        a_neg_c = a_signed_c & bus.rs1_val[XLEN-1];
        b_neg_c = b_signed_c & bus.rs2_val[XLEN-1];
        a_mag_c = a_neg_c ? XLEN'(-bus.rs1_val) : bus.rs1_val;
        b_mag_c = b_neg_c ? XLEN'(-bus.rs2_val) : bus.rs2_val;
    end

    // One shift-add / restoring-subtract step, plus final result selection and sign fix-up.
    always_comb begin
        mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : (XLEN + 1)'(0));
        div_shift_c = {hi_q, lo_q[XLEN-1]};
        div_ge_c    = (div_shift_c >= {1'b0, opnd_q});
        div_diff_c  = div_shift_c - {1'b0, opnd_q};

        prod_c = {hi_q, lo_q};
        if (neg_q) begin
            prod_c = PW'(-{hi_q, lo_q});
        end

        div_raw_c = op_q[1] ? hi_q : lo_q;
        if (neg_q) begin
            div_raw_c = XLEN'(-div_raw_c);
        end

        if (!op_q[2]) begin
            result_c = (op_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
        end else begin
            result_c = div_raw_c;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dest_d  = dest_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        rd_d    = rd_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.funct3;
                    dest_d = bus.rd_in;
                    cnt_d  = '0;
                    hi_d   = '0;
                    busy_d = 1'b1;
                    if (!bus.funct3[2]) begin
                        opnd_d = a_mag_c;
                        lo_d   = b_mag_c;
                        neg_d  = a_neg_c ^ b_neg_c;
                    end else begin
                        opnd_d = b_mag_c;
                        lo_d   = a_mag_c;
                        // Remainder follows the dividend; a zero divisor leaves the
                        // all-ones quotient unsigned.
                        if (bus.funct3[1]) begin
                            neg_d = a_neg_c;
                        end else begin
                            neg_d = (a_neg_c ^ b_neg_c) && (bus.rs2_val != '0);
                        end
                    end
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q != CNT_W'(ITERS)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!op_q[2]) begin
                        hi_d = mul_sum_c[XLEN:1];
                        lo_d = {mul_sum_c[0], lo_q[XLEN-1:1]};
                    end else if (div_ge_c) begin
                        hi_d = div_diff_c[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift_c[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    done_d  = 1'b1;
                    we_d    = (dest_q != 5'd0);
                    rd_d    = dest_q;
                    wdata_d = result_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.we    = we_q;
    assign bus.rd    = rd_q;
    assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: results, latency, handshake and abort behaviour.
module tb_muldiv_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
    endtask

    // Issue one op; optionally pulse a stray start at edge offset inject_at.
    task automatic do_op(input vec_t v, input int inject_at, input string tag);
        int k;
        bit found;
        @(negedge clk);
        drive_req(v.f3, v.a, v.b, v.rd);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drive_req(3'b101, 32'hDEAD_BEEF, 32'h0000_0003, 5'd17);
        chk({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        found = 1'b0;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.start) bus.start = 1'b0;
            if (i == inject_at) begin
                drive_req(3'b101, 32'd100, 32'd7, 5'd9);
                bus.start = 1'b1;
            end
            if (bus.done) begin
                found = 1'b1;
                k = i;
                break;
            end
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, found ? 32'(k) : 32'hFFFF_FFFF, 32'd33);
        if (found) begin
            chk({tag, " wdata"}, bus.wdata, v.exp);
            chk({tag, " rd"}, 32'(bus.rd), 32'(v.rd));
            chk({tag, " we"}, 32'(bus.we), (v.rd != 5'd0) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            chk({tag, " done_pulse_one_cycle"}, 32'(bus.done), 32'd0);
            chk({tag, " we_cleared"}, 32'(bus.we), 32'd0);
            chk({tag, " busy_cleared"}, 32'(bus.busy), 32'd0);
            chk({tag, " wdata_held"}, bus.wdata, v.exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        vec_t v;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        drive_req(3'b000, 32'h0, 32'h0, 5'd0);

        // f3, A, B, rd, expected wdata
        vecs.push_back('{3'b000, 32'd7,          32'd6,          5'd5,  32'h0000_002A});
        vecs.push_back('{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0001});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0000});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'hFFFF_FFFE});
        vecs.push_back('{3'b000, 32'h1234_5678,  32'h0000_0010,  5'd6,  32'h2345_6780});
        vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd7,  32'h4000_0000});
        vecs.push_back('{3'b011, 32'h8000_0000,  32'h0000_0002,  5'd8,  32'h0000_0001});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'hFFFF_FFFD});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd11, 32'hFFFF_FFFF});
        vecs.push_back('{3'b101, 32'd100,        32'd7,          5'd12, 32'd14});
        vecs.push_back('{3'b111, 32'd100,        32'd7,          5'd13, 32'd2});
        vecs.push_back('{3'b101, 32'h0000_1234,  32'd0,          5'd14, 32'hFFFF_FFFF});
        vecs.push_back('{3'b111, 32'h0000_1234,  32'd0,          5'd15, 32'h0000_1234});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'h0000_0000});
        vecs.push_back('{3'b100, 32'hFFFF_FFFB,  32'd0,          5'd19, 32'hFFFF_FFFF});
        vecs.push_back('{3'b110, 32'hFFFF_FFFB,  32'd0,          5'd20, 32'hFFFF_FFFB});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF});

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset we", 32'(bus.we), 32'd0);
        chk("reset rd", 32'(bus.rd), 32'd0);
        chk("reset wdata", bus.wdata, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Stray start at cycle +10 of an active op must be ignored.
        v = '{3'b000, 32'd7, 32'd6, 5'd5, 32'h0000_002A};
        do_op(v, 10, "start_while_busy");

        // rd = 0: completes, but no register file write.
        v = '{3'b101, 32'd100, 32'd7, 5'd0, 32'd14};
        do_op(v, 0, "rd_zero");

        // Abort at CALC iteration 15.
        @(negedge clk);
        drive_req(3'b000, 32'd9, 32'd9, 5'd3);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort we", 32'(bus.we), 32'd0);
        chk("abort wdata", bus.wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.we) seen++;
        end
        chk("abort no_write_after", 32'(seen), 32'd0);

        v = '{3'b010, 32'hFFFF_FFFE, 32'd3, 5'd22, 32'hFFFF_FFFF};
        do_op(v, 0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
